// File: rtl/grf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : grf_scoreboard
// Description : 32 x DATA_W MIPS general register file with two combinational
//               read ports, one write-back port and a per-register
//               pending-write scoreboard (saturating counters) that decode
//               uses to stall on in-flight writes.
// Option      : GRF_WB_BYPASS_EN - same-cycle write-back to read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        RA1,
  input  logic [4:0]        RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [4:0]        WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              We,
  input  logic              issue_valid,
  input  logic [4:0]        issue_addr,
  output logic              busy1,
  output logic              busy2,
  output logic              issue_full
);

  localparam logic [PEND_W-1:0] C_CNT_MAX = '1;
  localparam logic [PEND_W-1:0] C_CNT_ONE = PEND_W'(1);

  // $0 is hard-wired to zero, so only entries 1..31 are stored.
  logic [DATA_W-1:0] r_grf [1:31];
  logic [PEND_W-1:0] r_cnt [1:31];

  logic              w_inc;
  logic [PEND_W-1:0] w_cnt1;
  logic [PEND_W-1:0] w_cnt2;
  logic [PEND_W-1:0] w_cnt_issue;
  logic              w_hit1;
  logic              w_hit2;

  // An issue is accepted only for a real destination whose counter has room.
  assign w_inc = issue_valid && (issue_addr != 5'd0) && !issue_full;

  generate
    for (genvar i = 1; i < 32; i++) begin : g_reg
      localparam logic [4:0] C_IDX = 5'(i);
      logic w_inc_i;
      logic w_dec_i;

      assign w_inc_i = w_inc && (issue_addr == C_IDX);
      // A retire on an idle counter still writes the data but leaves the count at 0.
      assign w_dec_i = We && (WA == C_IDX) && (r_cnt[i] != '0);

      // Register storage: written by the write-back port.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_grf[i] <= '0;
        end else if (We && (WA == C_IDX)) begin
          r_grf[i] <= WD;
        end
      end

      // Pending-write counter: issue increments, retire decrements, both cancel.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt[i] <= '0;
        end else if (w_inc_i && !w_dec_i) begin
          r_cnt[i] <= r_cnt[i] + C_CNT_ONE;
        end else if (w_dec_i && !w_inc_i) begin
          r_cnt[i] <= r_cnt[i] - C_CNT_ONE;
        end
      end
    end
  endgenerate

  // Read ports, busy flags and issue-full lookup; address 0 reads as idle zero.
  always_comb begin
    RD1         = '0;
    RD2         = '0;
    w_cnt1      = '0;
    w_cnt2      = '0;
    w_cnt_issue = '0;
    w_hit1      = 1'b0;
    w_hit2      = 1'b0;
    if (RA1 != 5'd0) begin
      RD1    = r_grf[RA1];
      w_cnt1 = r_cnt[RA1];
    end
    if (RA2 != 5'd0) begin
      RD2    = r_grf[RA2];
      w_cnt2 = r_cnt[RA2];
    end
    if (issue_addr != 5'd0) begin
      w_cnt_issue = r_cnt[issue_addr];
    end
`ifdef GRF_WB_BYPASS_EN
    // Reset gating keeps a live write-back from leaking through while in reset.
    w_hit1 = reset_n && We && (WA == RA1) && (WA != 5'd0);
    w_hit2 = reset_n && We && (WA == RA2) && (WA != 5'd0);
    if (w_hit1) begin
      RD1 = WD;
    end
    if (w_hit2) begin
      RD2 = WD;
    end
`endif
    // A retire of the last pending write only masks busy when it is bypassed.
    busy1      = (w_cnt1 != '0) && !(w_hit1 && (w_cnt1 == C_CNT_ONE));
    busy2      = (w_cnt2 != '0) && !(w_hit2 && (w_cnt2 == C_CNT_ONE));
    issue_full = (w_cnt_issue == C_CNT_MAX);
  end

endmodule
`default_nettype wire
